// File: rtl/mem_arbiter.sv
// Arbitrates the shared 128-bit line memory port between icache and dcache.
// Optional `ARB_RR_EN selects round-robin arbitration instead of fixed dcache priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_owner;
  logic                w_owner_nxt;
  logic                r_last;
  logic                w_last_nxt;
  logic                r_mem_read;
  logic                w_mem_read_nxt;
  logic                r_mem_write;
  logic                w_mem_write_nxt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [LINE_W-1:0]   r_mem_wdata;
  logic [LINE_W-1:0]   w_mem_wdata_nxt;

  logic w_i_req;
  logic w_d_req;
  logic w_any_req;
  logic w_pick_d;
  logic w_complete;
  logic w_i_match;
  logic w_d_match;

  assign w_i_req   = i_read;
  assign w_d_req   = d_read | d_write;
  assign w_any_req = w_i_req | w_d_req;

`ifdef ARB_RR_EN
  // Contended grant goes to whichever side did not win last time.
  assign w_pick_d = w_d_req & (~w_i_req | (r_last == OWN_I));
`else
  assign w_pick_d = w_d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_I;
      r_last      <= OWN_I;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_last      <= w_last_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_last_nxt      = r_last;
    w_mem_read_nxt  = r_mem_read;
    w_mem_write_nxt = r_mem_write;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_BUSY;
          w_owner_nxt = w_pick_d;
          w_last_nxt  = w_pick_d;
          if (w_pick_d) begin
            w_mem_read_nxt  = d_read;
            w_mem_write_nxt = d_write;
            w_mem_addr_nxt  = d_addr;
            w_mem_wdata_nxt = d_write ? d_wdata : '0;
          end else begin
            w_mem_read_nxt  = 1'b1;
            w_mem_write_nxt = 1'b0;
            w_mem_addr_nxt  = i_addr;
            w_mem_wdata_nxt = '0;
          end
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          w_state_nxt     = ST_DONE;
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_mem_read_nxt  = 1'b0;
        w_mem_write_nxt = 1'b0;
      end
    endcase
  end

  // A completion is delivered only if the owner still wants exactly the latched line.
  assign w_complete = (r_state == ST_BUSY) & mem_ready;
  assign w_i_match  = i_read & (i_addr == r_mem_addr);
  assign w_d_match  = r_mem_write ? (d_write & (d_addr == r_mem_addr))
                                  : (d_read  & (d_addr == r_mem_addr));

  assign i_ready = w_complete & (r_owner == OWN_I) & w_i_match;
  assign d_ready = w_complete & (r_owner == OWN_D) & w_d_match;
  assign i_rdata = i_ready ? mem_rdata : '0;
  assign d_rdata = (d_ready & ~r_mem_write) ? mem_rdata : '0;

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle-by-cycle vector bench for mem_arbiter (fixed or `ARB_RR_EN build).
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned LINE_W = 128;

  logic              clk;
  logic              rst_n;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_ready;
  logic [LINE_W-1:0] d_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_rdata   (i_rdata),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              ir;
    logic [ADDR_W-1:0] ia;
    logic              dr;
    logic              dw;
    logic [ADDR_W-1:0] da;
    logic [LINE_W-1:0] dwd;
    logic              mr;
    logic [LINE_W-1:0] mrd;
    logic              e_rd;
    logic              e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wdata;
    logic              e_ir;
    logic              e_dr;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  localparam logic [LINE_W-1:0] D1 = {4{32'hD1D1_0001}};
  localparam logic [LINE_W-1:0] D2 = {4{32'hD2D2_0002}};
  localparam logic [LINE_W-1:0] D3 = {4{32'hD3D3_0003}};
  localparam logic [LINE_W-1:0] D4 = {4{32'hD4D4_0004}};
  localparam logic [LINE_W-1:0] D5 = {4{32'hD5D5_0005}};
  localparam logic [LINE_W-1:0] D6 = {4{32'hD6D6_0006}};
  localparam logic [LINE_W-1:0] D7 = {4{32'hD7D7_0007}};
  localparam logic [LINE_W-1:0] W1 = {4{32'hA1A1_1111}};
  localparam logic [LINE_W-1:0] W2 = {4{32'hA2A2_2222}};
  localparam logic [LINE_W-1:0] W3 = {4{32'hA3A3_3333}};
  localparam logic [LINE_W-1:0] W4 = {4{32'hA4A4_4444}};
  localparam logic [LINE_W-1:0] Z  = '0;

  function automatic vec_t v(input logic ir, input logic [ADDR_W-1:0] ia,
                             input logic dr, input logic dw, input logic [ADDR_W-1:0] da,
                             input logic [LINE_W-1:0] dwd, input logic mr,
                             input logic [LINE_W-1:0] mrd, input logic e_rd, input logic e_wr,
                             input logic [ADDR_W-1:0] e_addr, input logic [LINE_W-1:0] e_wdata,
                             input logic e_ir, input logic e_dr);
    vec_t t;
    t.ir = ir; t.ia = ia; t.dr = dr; t.dw = dw; t.da = da; t.dwd = dwd;
    t.mr = mr; t.mrd = mrd; t.e_rd = e_rd; t.e_wr = e_wr; t.e_addr = e_addr;
    t.e_wdata = e_wdata; t.e_ir = e_ir; t.e_dr = e_dr;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    logic [ADDR_W-1:0] la;
    // Columns: ir ia dr dw da dwd mr mrd | mem_read mem_write mem_addr mem_wdata i_ready d_ready
    vecs.push_back(v(1, 28'h123, 0, 0, 0, Z, 0, Z,  0, 0, 0, Z, 0, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(v(1, 28'h123, 0, 0, 0, Z, 0, Z,  1, 0, 28'h123, Z, 0, 0));
    vecs.push_back(v(1, 28'h123, 0, 0, 0, Z, 1, D1, 1, 0, 28'h123, Z, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, Z, 1, D1,       0, 0, 28'h123, Z, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, Z, 1, D1,       0, 0, 28'h123, Z, 0, 0));
    vecs.push_back(v(1, 28'h55, 0, 1, 28'hAB, W1, 0, Z, 0, 0, 28'h123, Z, 0, 0));
    vecs.push_back(v(1, 28'h55, 0, 1, 28'hAB, W2, 0, Z, 0, 1, 28'hAB, W1, 0, 0));
    vecs.push_back(v(1, 28'h55, 0, 1, 28'hAB, W3, 1, Z, 0, 1, 28'hAB, W1, 0, 1));
    vecs.push_back(v(1, 28'h55, 1, 0, 28'h77, Z, 0, Z,  0, 0, 28'hAB, W1, 0, 0));
    vecs.push_back(v(1, 28'h55, 1, 0, 28'h77, Z, 0, Z,  0, 0, 28'hAB, W1, 0, 0));
`ifdef ARB_RR_EN
    // last=D here, so the contended grant goes to the icache.
    vecs.push_back(v(1, 28'h55, 1, 0, 28'h77, Z, 1, D2, 1, 0, 28'h55, Z, 1, 0));
    vecs.push_back(v(0, 0, 1, 0, 28'h77, Z, 0, Z,       0, 0, 28'h55, Z, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 28'h77, Z, 0, Z,       0, 0, 28'h55, Z, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 28'h77, Z, 1, D3,      1, 0, 28'h77, Z, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, Z, 0, Z,            0, 0, 28'h77, Z, 0, 0));
    la = 28'h77;
`else
    vecs.push_back(v(1, 28'h55, 1, 0, 28'h77, Z, 1, D2, 1, 0, 28'h77, Z, 0, 1));
    vecs.push_back(v(1, 28'h55, 0, 0, 0, Z, 0, Z,       0, 0, 28'h77, Z, 0, 0));
    vecs.push_back(v(1, 28'h55, 0, 0, 0, Z, 0, Z,       0, 0, 28'h77, Z, 0, 0));
    vecs.push_back(v(1, 28'h55, 0, 0, 0, Z, 1, D3,      1, 0, 28'h55, Z, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, Z, 0, Z,            0, 0, 28'h55, Z, 0, 0));
    la = 28'h55;
`endif
    // Stale prefetch: granted at 0x10, redirected to 0x40.
    vecs.push_back(v(1, 28'h10, 0, 0, 0, Z, 0, Z,  0, 0, la, Z, 0, 0));
    vecs.push_back(v(1, 28'h40, 0, 0, 0, Z, 0, Z,  1, 0, 28'h10, Z, 0, 0));
    vecs.push_back(v(1, 28'h40, 0, 0, 0, Z, 1, D4, 1, 0, 28'h10, Z, 0, 0));
    vecs.push_back(v(1, 28'h40, 0, 0, 0, Z, 0, Z,  0, 0, 28'h10, Z, 0, 0));
    vecs.push_back(v(1, 28'h40, 0, 0, 0, Z, 0, Z,  0, 0, 28'h10, Z, 0, 0));
    vecs.push_back(v(1, 28'h40, 0, 0, 0, Z, 1, D5, 1, 0, 28'h40, Z, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, Z, 0, Z,       0, 0, 28'h40, Z, 0, 0));
    // Back-to-back dcache write 0x20 then read 0x30.
    vecs.push_back(v(0, 0, 0, 1, 28'h20, W4, 0, Z, 0, 0, 28'h40, Z, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 28'h20, W4, 1, Z, 0, 1, 28'h20, W4, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 28'h30, Z, 0, Z,  0, 0, 28'h20, W4, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 28'h30, Z, 0, Z,  0, 0, 28'h20, W4, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 28'h30, Z, 1, D6, 1, 0, 28'h30, Z, 0, 1));
    // Request raised in DONE then dropped before IDLE: never issued.
    vecs.push_back(v(1, 28'h99, 0, 0, 0, Z, 0, Z,  0, 0, 28'h30, Z, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, Z, 1, D7,      0, 0, 28'h30, Z, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, Z, 0, Z,       0, 0, 28'h30, Z, 0, 0));

    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read",  {127'b0, mem_read},  Z);
    chk("rst_mem_write", {127'b0, mem_write}, Z);
    chk("rst_mem_addr",  {100'b0, mem_addr},  Z);
    chk("rst_i_ready",   {127'b0, i_ready},   Z);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted in BUSY while a matching completion is on the port.
    @(posedge clk); #1;
    i_read = 1'b1; i_addr = 28'h5A;
    @(posedge clk); #1;
    chk("pre_rst_mem_read", {127'b0, mem_read}, 128'd1);
    chk("pre_rst_mem_addr", {100'b0, mem_addr}, 128'h5A);
    mem_ready = 1'b1; mem_rdata = D1;
    #1;
    chk("pre_rst_i_ready", {127'b0, i_ready}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_read", {127'b0, mem_read}, Z);
    chk("midrst_i_ready",  {127'b0, i_ready},  Z);
    chk("midrst_d_ready",  {127'b0, d_ready},  Z);
    chk("midrst_i_rdata",  i_rdata,            Z);
    chk("midrst_mem_addr", {100'b0, mem_addr}, Z);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("postrst_mem_read",  {127'b0, mem_read},  Z);
    chk("postrst_mem_write", {127'b0, mem_write}, Z);

    for (int n = 0; n < vecs.size(); n++) begin
      vec_t t;
      logic [LINE_W-1:0] e_ird;
      logic [LINE_W-1:0] e_drd;
      t = vecs[n];
      if (n != 0) begin
        @(posedge clk);
        #1;
      end
      i_read = t.ir; i_addr = t.ia; d_read = t.dr; d_write = t.dw;
      d_addr = t.da; d_wdata = t.dwd; mem_ready = t.mr; mem_rdata = t.mrd;
      @(negedge clk);
      e_ird = t.e_ir ? t.mrd : Z;
      e_drd = (t.e_dr && !t.e_wr) ? t.mrd : Z;
      chk($sformatf("v%0d_mem_read", n),  {127'b0, mem_read},  {127'b0, t.e_rd});
      chk($sformatf("v%0d_mem_write", n), {127'b0, mem_write}, {127'b0, t.e_wr});
      chk($sformatf("v%0d_mem_addr", n),  {100'b0, mem_addr},  {100'b0, t.e_addr});
      chk($sformatf("v%0d_mem_wdata", n), mem_wdata,           t.e_wdata);
      chk($sformatf("v%0d_i_ready", n),   {127'b0, i_ready},   {127'b0, t.e_ir});
      chk($sformatf("v%0d_d_ready", n),   {127'b0, d_ready},   {127'b0, t.e_dr});
      chk($sformatf("v%0d_i_rdata", n),   i_rdata,             e_ird);
      chk($sformatf("v%0d_d_rdata", n),   d_rdata,             e_drd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
